// File: rtl/rb_fifo_pkg.sv
// Shared defaults, count width and FSM state encoding for the round-robin
// FIFO push arbiter.
package rb_fifo_pkg;

  localparam int unsigned NREQ_DEF  = 3;
  localparam int unsigned MSBD_DEF  = 3;
  localparam int unsigned DEPTH_DEF = 16;
  localparam int unsigned CNT_W     = $clog2(DEPTH_DEF + 1);

  typedef enum logic [1:0] {
    RUN,
    DRAIN,
    DONE
  } state_t;

  // Width of an index into NREQ producers, never less than one bit.
  function automatic int unsigned idx_w(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin pick: the first requester after lastIdx in ascending order,
// wrapping from NREQ-1 back to 0. Grant is all-zero when not enabled.
module rr_arbiter #(
  parameter int unsigned NREQ = 3,
  parameter int unsigned IW   = 2
) (
  input  logic [NREQ-1:0] req,
  input  logic [IW-1:0]   lastIdx,
  input  logic            enable,
  output logic [NREQ-1:0] grant,
  output logic [IW-1:0]   idx
);

  logic [IW-1:0] cand;
  logic          found;

  always_comb begin
    grant = '0;
    idx   = '0;
    found = 1'b0;
    cand  = '0;
    for (int unsigned off = 1; off <= NREQ; off++) begin
      cand = IW'((32'(lastIdx) + off) % NREQ);
      if (enable && !found && req[cand]) begin
        grant[cand] = 1'b1;
        idx         = cand;
        found       = 1'b1;
      end
    end
  end

endmodule

// File: rtl/rb_fifo_arbiter.sv
// Shares one FIFO push port among NREQ producers with round-robin grant,
// pop priority, a drain FSM and a mirrored occupancy count checked against
// the partner FIFO's flags.
module rb_fifo_arbiter
  import rb_fifo_pkg::*;
#(
  parameter int unsigned NREQ  = NREQ_DEF,
  parameter int unsigned MSBD  = MSBD_DEF,
  parameter int unsigned DEPTH = DEPTH_DEF
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic [NREQ-1:0]            reqPush,
  input  logic [NREQ*(MSBD+1)-1:0]   reqData,
  output logic [NREQ-1:0]            grant,
  input  logic                       popReq,
  output logic                       popAck,
  input  logic                       drain,
  output logic                       drainDone,
  output logic                       fifoPush,
  output logic [MSBD:0]              fifoDataIn,
  output logic                       fifoPop,
  input  logic                       fifoFull,
  input  logic                       fifoEmpty,
  output logic [$clog2(DEPTH+1)-1:0] count,
  output logic                       syncErr
);

  localparam int unsigned W  = MSBD + 1;
  localparam int unsigned CW = $clog2(DEPTH + 1);
  localparam int unsigned IW = idx_w(NREQ);
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

  state_t        state;
  logic [IW-1:0] last_idx;
  logic [IW-1:0] arb_idx;
  logic          pop_ok;
  logic          push_ok;

  // Pop wins over push; both are masked while reset is held.
  always_comb begin
    pop_ok  = !reset && popReq && (count != '0);
    push_ok = !reset && !pop_ok && (count < FULL_CNT) && (state == RUN) && (|reqPush);
  end

  rr_arbiter #(
    .NREQ (NREQ),
    .IW   (IW)
  ) u_rr_arbiter (
    .req     (reqPush),
    .lastIdx (last_idx),
    .enable  (push_ok),
    .grant   (grant),
    .idx     (arb_idx)
  );

  always_comb begin
    popAck     = pop_ok;
    fifoPop    = pop_ok;
    fifoPush   = push_ok;
    fifoDataIn = '0;
    if (push_ok)
      fifoDataIn = reqData[32'(arb_idx)*W +: W];
  end

  assign drainDone = (state == DONE);

  always_ff @(posedge clock) begin
    if (reset) begin
      count    <= '0;
      last_idx <= IW'(NREQ - 1);
      state    <= RUN;
      syncErr  <= 1'b0;
    end else begin
      if (push_ok) begin
        count    <= count + CW'(1);
        last_idx <= arb_idx;
      end else if (pop_ok) begin
        count    <= count - CW'(1);
      end

      if (((count == '0) != fifoEmpty) || ((count == FULL_CNT) != fifoFull))
        syncErr <= 1'b1;

      case (state)
        RUN:     if (drain) state <= DRAIN;
        DRAIN: begin
          if (count == '0)  state <= DONE;
          else if (!drain)  state <= RUN;
        end
        DONE:    if (!drain) state <= RUN;
        default: state <= RUN;
      endcase
    end
  end

endmodule

// File: tb/tb_rb_fifo_arbiter.sv
// Directed bench for rb_fifo_arbiter with a behavioural partner-FIFO
// occupancy model driving the full/empty flags.
module tb_rb_fifo_arbiter;

  localparam int unsigned NREQ  = 3;
  localparam int unsigned MSBD  = 3;
  localparam int unsigned DEPTH = 16;
  localparam int unsigned CW    = $clog2(DEPTH + 1);

  logic                     clock = 1'b0;
  logic                     reset;
  logic [NREQ-1:0]          reqPush;
  logic [NREQ*(MSBD+1)-1:0] reqData;
  logic [NREQ-1:0]          grant;
  logic                     popReq;
  logic                     popAck;
  logic                     drain;
  logic                     drainDone;
  logic                     fifoPush;
  logic [MSBD:0]            fifoDataIn;
  logic                     fifoPop;
  logic                     fifoFull;
  logic                     fifoEmpty;
  logic [CW-1:0]            count;
  logic                     syncErr;

  int  n_checks = 0;
  int  n_pass   = 0;
  int  mcount   = 0;
  bit  force_ne = 1'b0;

  rb_fifo_arbiter #(
    .NREQ  (NREQ),
    .MSBD  (MSBD),
    .DEPTH (DEPTH)
  ) dut (
    .clock      (clock),
    .reset      (reset),
    .reqPush    (reqPush),
    .reqData    (reqData),
    .grant      (grant),
    .popReq     (popReq),
    .popAck     (popAck),
    .drain      (drain),
    .drainDone  (drainDone),
    .fifoPush   (fifoPush),
    .fifoDataIn (fifoDataIn),
    .fifoPop    (fifoPop),
    .fifoFull   (fifoFull),
    .fifoEmpty  (fifoEmpty),
    .count      (count),
    .syncErr    (syncErr)
  );

  always #5 clock = ~clock;

  // Partner FIFO: occupancy follows the strobes, flags derived from it.
  always @(posedge clock) begin
    if (reset)         mcount <= 0;
    else if (fifoPush) mcount <= mcount + 1;
    else if (fifoPop)  mcount <= mcount - 1;
  end
  assign fifoEmpty = force_ne ? 1'b0 : (mcount == 0);
  assign fifoFull  = (mcount == DEPTH);

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
  endtask

  // Advance one clock; inputs change after the falling edge.
  task automatic tick();
    @(posedge clock);
    @(negedge clock);
  endtask

  initial begin
    reset   = 1'b1;
    reqPush = 3'b111;
    reqData = 12'hCBA;   // slice0=A, slice1=B, slice2=C
    popReq  = 1'b1;
    drain   = 1'b0;
    #1;
    check("rst_grant", 32'(grant), 0);
    check("rst_push", 32'(fifoPush), 0);
    check("rst_popack", 32'(popAck), 0);
    check("rst_fifopop", 32'(fifoPop), 0);
    tick();
    tick();
    check("rst_count", 32'(count), 0);
    check("rst_syncerr", 32'(syncErr), 0);
    check("rst_drdone", 32'(drainDone), 0);

    // Round-robin across all three producers.
    reset = 1'b0; popReq = 1'b0; reqPush = 3'b111; #1;
    check("rr0_grant", 32'(grant), 32'b001);
    check("rr0_data", 32'(fifoDataIn), 32'hA);
    tick(); #1;
    check("rr1_grant", 32'(grant), 32'b010);
    check("rr1_data", 32'(fifoDataIn), 32'hB);
    tick(); #1;
    check("rr2_grant", 32'(grant), 32'b100);
    check("rr2_data", 32'(fifoDataIn), 32'hC);
    tick(); #1;
    check("rr3_grant", 32'(grant), 32'b001);
    tick(); #1;
    check("rr_count4", 32'(count), 4);

    // Fill to DEPTH with producer 0 only.
    reqPush = 3'b001;
    for (int i = 0; i < 12; i++) tick();
    #1;
    check("full_count", 32'(count), 16);
    check("full_grant", 32'(grant), 0);
    check("full_push", 32'(fifoPush), 0);
    check("full_data", 32'(fifoDataIn), 0);
    tick(); #1;
    check("full_hold", 32'(count), 16);
    check("full_syncerr", 32'(syncErr), 0);

    // Pop down to 5, then pop and push contend.
    reqPush = 3'b000; popReq = 1'b1;
    for (int i = 0; i < 11; i++) tick();
    #1;
    check("pp_count5", 32'(count), 5);
    reqPush = 3'b010; #1;
    check("pp_popack", 32'(popAck), 1);
    check("pp_fifopop", 32'(fifoPop), 1);
    check("pp_grant", 32'(grant), 0);
    check("pp_push", 32'(fifoPush), 0);
    tick();
    popReq = 1'b0; #1;
    check("pp_count4", 32'(count), 4);
    check("pp_grant2", 32'(grant), 32'b010);
    check("pp_data2", 32'(fifoDataIn), 32'hB);
    tick(); #1;
    check("pp_count5b", 32'(count), 5);

    // Drain from 3 with pops running.
    reqPush = 3'b000; popReq = 1'b1;
    tick(); tick(); #1;
    check("dr_count3", 32'(count), 3);
    drain = 1'b1; reqPush = 3'b111; #1;
    check("dr_grant3", 32'(grant), 0);
    tick(); #1;
    check("dr_count2", 32'(count), 2);
    check("dr_grant2", 32'(grant), 0);
    tick(); #1;
    check("dr_count1", 32'(count), 1);
    tick(); #1;
    check("dr_count0", 32'(count), 0);
    check("dr_notdone", 32'(drainDone), 0);
    check("dr_grant0", 32'(grant), 0);
    check("dr_popack0", 32'(popAck), 0);
    tick(); #1;
    check("dr_done", 32'(drainDone), 1);
    check("dr_done_grant", 32'(grant), 0);
    drain = 1'b0; popReq = 1'b0; #1;
    check("dr_exit_grant", 32'(grant), 0);
    tick(); #1;
    check("dr_run", 32'(drainDone), 0);
    check("dr_resume", 32'(grant), 32'b100);
    check("dr_resume_data", 32'(fifoDataIn), 32'hC);
    tick(); #1;
    check("dr_count_r1", 32'(count), 1);

    // Empty pop is refused.
    reqPush = 3'b000; popReq = 1'b1;
    tick(); #1;
    check("em_count0", 32'(count), 0);
    check("em_popack", 32'(popAck), 0);
    check("em_fifopop", 32'(fifoPop), 0);
    tick(); #1;
    check("em_hold", 32'(count), 0);

    // Drain rising with a push request still grants that cycle.
    popReq = 1'b0; reqPush = 3'b001;
    for (int i = 0; i < 6; i++) tick();
    #1;
    check("dp_count6", 32'(count), 6);
    drain = 1'b1; #1;
    check("dp_grant", 32'(grant), 32'b001);
    tick(); #1;
    check("dp_count7", 32'(count), 7);
    check("dp_blocked", 32'(grant), 0);

    // Reset mid-drain.
    reset = 1'b1; reqPush = 3'b111; popReq = 1'b1; #1;
    check("mr_grant", 32'(grant), 0);
    check("mr_popack", 32'(popAck), 0);
    tick();
    reset = 1'b0; drain = 1'b0; popReq = 1'b0; #1;
    check("mr_count", 32'(count), 0);
    check("mr_grant_run", 32'(grant), 32'b001);
    tick();
    reqPush = 3'b000; popReq = 1'b1;
    tick(); #1;
    check("mr_count0", 32'(count), 0);

    // Flag disagreement is sticky until reset.
    popReq = 1'b0; force_ne = 1'b1; #1;
    check("se_before", 32'(syncErr), 0);
    tick(); #1;
    check("se_set", 32'(syncErr), 1);
    force_ne = 1'b0;
    tick(); tick(); #1;
    check("se_sticky", 32'(syncErr), 1);
    reset = 1'b1;
    tick();
    reset = 1'b0; #1;
    check("se_cleared", 32'(syncErr), 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
